// File: rtl/rs_pkg.sv
// rtl/rs_pkg.sv - shared types, default widths and age-rank sizing for reservation stations
package rs_pkg;

  localparam int RS_ENTRIES = 4;
  localparam int RS_DATA_W  = 32;
  localparam int RS_TAG_W   = 5;
  localparam int RS_OP_W    = 6;

  // Age ranks run 0..ENTRIES-1 (0 = oldest busy entry).
  function automatic int rs_rank_w(input int entries);
    return (entries > 1) ? $clog2(entries) : 1;
  endfunction

  localparam int RS_RANK_W = rs_rank_w(RS_ENTRIES);

  // Entry layout at the default widths.
  typedef struct packed {
    logic [RS_OP_W-1:0]   op;
    logic [RS_TAG_W-1:0]  dest;
    logic                 a_rdy;
    logic [RS_TAG_W-1:0]  a_tag;
    logic [RS_DATA_W-1:0] a_val;
    logic                 b_rdy;
    logic [RS_TAG_W-1:0]  b_tag;
    logic [RS_DATA_W-1:0] b_val;
  } rs_entry_t;

endpackage

// File: rtl/rs_age_select.sv
// rtl/rs_age_select.sv - combinational oldest-candidate picker over per-entry age ranks
//
// Ports:
//   cand  - candidate vector (busy and fully ready)
//   rank  - per-entry age rank, lower is older, unique among busy entries
//   grant - one-hot winner (all zero when no candidate)
//   found - at least one candidate exists
module rs_age_select #(
  parameter int ENTRIES = 4,
  parameter int RANK_W  = 2
) (
  input  logic [ENTRIES-1:0]             cand,
  input  logic [ENTRIES-1:0][RANK_W-1:0] rank,
  output logic [ENTRIES-1:0]             grant,
  output logic                           found
);

  // A candidate wins when no other candidate carries a smaller rank.
  always_comb begin
    grant = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      grant[i] = cand[i];
      for (int j = 0; j < ENTRIES; j++) begin
        if (j != i && cand[j] && (rank[j] < rank[i])) begin
          grant[i] = 1'b0;
        end
      end
    end
  end

  assign found = |cand;

endmodule

// File: rtl/reservation_station_param.sv
// rtl/reservation_station_param.sv - parametrised reservation station with CDB wakeup and age-ordered dispatch
//
// Optional build macro: RS_ISSUE_WAKEUP_EN (an operand issued not-ready captures a
// matching same-cycle CDB broadcast instead of waiting for a later one).
//
// Ports:
//   clk, rst (async, active-low), flush (sync clear of entries and output stage)
//   in_valid/in_ready, in_op, in_dest, in_{a,b}_rdy/_tag/_val - issue side
//   cdb_valid, cdb_tag, cdb_data                              - result broadcast
//   out_valid/out_ready, out_op, out_dest, out_a, out_b        - registered dispatch stage
//   count                                                      - occupied slots
module reservation_station_param
  import rs_pkg::*;
#(
  parameter int ENTRIES = RS_ENTRIES,
  parameter int DATA_W  = RS_DATA_W,
  parameter int TAG_W   = RS_TAG_W,
  parameter int OP_W    = RS_OP_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [OP_W-1:0]          in_op,
  input  logic [TAG_W-1:0]         in_dest,
  input  logic                     in_a_rdy,
  input  logic                     in_b_rdy,
  input  logic [TAG_W-1:0]         in_a_tag,
  input  logic [TAG_W-1:0]         in_b_tag,
  input  logic [DATA_W-1:0]        in_a_val,
  input  logic [DATA_W-1:0]        in_b_val,
  input  logic                     cdb_valid,
  input  logic [TAG_W-1:0]         cdb_tag,
  input  logic [DATA_W-1:0]        cdb_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OP_W-1:0]          out_op,
  output logic [TAG_W-1:0]         out_dest,
  output logic [DATA_W-1:0]        out_a,
  output logic [DATA_W-1:0]        out_b,
  output logic [$clog2(ENTRIES):0] count
);

  localparam int RANK_W = rs_rank_w(ENTRIES);
  localparam int CNT_W  = $clog2(ENTRIES) + 1;

  logic [ENTRIES-1:0]             busy, a_rdy, b_rdy;
  logic [OP_W-1:0]                op_q   [ENTRIES];
  logic [TAG_W-1:0]               dest_q [ENTRIES];
  logic [TAG_W-1:0]               a_tag  [ENTRIES];
  logic [TAG_W-1:0]               b_tag  [ENTRIES];
  logic [DATA_W-1:0]              a_val  [ENTRIES];
  logic [DATA_W-1:0]              b_val  [ENTRIES];
  logic [ENTRIES-1:0][RANK_W-1:0] rank;

  logic [ENTRIES-1:0] cand, grant, free_oh, a_hit, b_hit;
  logic               found, load, disp, do_issue, iss_a_hit, iss_b_hit;
  logic [OP_W-1:0]    win_op;
  logic [TAG_W-1:0]   win_dest;
  logic [DATA_W-1:0]  win_a, win_b;
  logic [RANK_W-1:0]  win_rank, new_rank;

  assign in_ready = count < CNT_W'(ENTRIES);
  assign do_issue = in_valid && in_ready && !flush;
  assign cand     = busy & a_rdy & b_rdy;
  assign load     = !out_valid || out_ready;
  assign disp     = load && found;

  // Lowest clear bit of busy: the +1 carries through the trailing ones.
  assign free_oh  = ~busy & (busy + ENTRIES'(1));

  // A new entry is younger than every entry that stays busy past this edge.
  assign new_rank = RANK_W'(count - CNT_W'(disp));

`ifdef RS_ISSUE_WAKEUP_EN
  assign iss_a_hit = !in_a_rdy && cdb_valid && (in_a_tag == cdb_tag);
  assign iss_b_hit = !in_b_rdy && cdb_valid && (in_b_tag == cdb_tag);
`else
  assign iss_a_hit = 1'b0;
  assign iss_b_hit = 1'b0;
`endif

  rs_age_select #(
    .ENTRIES (ENTRIES),
    .RANK_W  (RANK_W)
  ) u_age_select (
    .cand  (cand),
    .rank  (rank),
    .grant (grant),
    .found (found)
  );

  // Ready operands never match, so a stale tag cannot clobber a captured value.
  always_comb begin
    a_hit = '0;
    b_hit = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      a_hit[i] = busy[i] && !a_rdy[i] && cdb_valid && (a_tag[i] == cdb_tag);
      b_hit[i] = busy[i] && !b_rdy[i] && cdb_valid && (b_tag[i] == cdb_tag);
    end
  end

  always_comb begin
    win_op   = '0;
    win_dest = '0;
    win_a    = '0;
    win_b    = '0;
    win_rank = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (grant[i]) begin
        win_op   |= op_q[i];
        win_dest |= dest_q[i];
        win_a    |= a_val[i];
        win_b    |= b_val[i];
        win_rank |= rank[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy  <= '0;
      a_rdy <= '0;
      b_rdy <= '0;
      rank  <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        op_q[i]   <= '0;
        dest_q[i] <= '0;
        a_tag[i]  <= '0;
        b_tag[i]  <= '0;
        a_val[i]  <= '0;
        b_val[i]  <= '0;
      end
    end else if (flush) begin
      busy <= '0;
      rank <= '0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (a_hit[i]) begin
          a_rdy[i] <= 1'b1;
          a_val[i] <= cdb_data;
        end
        if (b_hit[i]) begin
          b_rdy[i] <= 1'b1;
          b_val[i] <= cdb_data;
        end
        // Entries younger than the departing winner move up one rank.
        if (disp && busy[i] && (rank[i] > win_rank)) begin
          rank[i] <= rank[i] - RANK_W'(1);
        end
        if (disp && grant[i]) begin
          busy[i] <= 1'b0;
        end
        if (do_issue && free_oh[i]) begin
          busy[i]   <= 1'b1;
          rank[i]   <= new_rank;
          op_q[i]   <= in_op;
          dest_q[i] <= in_dest;
          a_tag[i]  <= in_a_tag;
          b_tag[i]  <= in_b_tag;
          a_rdy[i]  <= in_a_rdy || iss_a_hit;
          b_rdy[i]  <= in_b_rdy || iss_b_hit;
          a_val[i]  <= in_a_rdy ? in_a_val : (iss_a_hit ? cdb_data : '0);
          b_val[i]  <= in_b_rdy ? in_b_val : (iss_b_hit ? cdb_data : '0);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_op    <= '0;
      out_dest  <= '0;
      out_a     <= '0;
      out_b     <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (load) begin
      out_valid <= found;
      if (found) begin
        out_op   <= win_op;
        out_dest <= win_dest;
        out_a    <= win_a;
        out_b    <= win_b;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (flush) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(do_issue) - CNT_W'(disp);
    end
  end

endmodule
